// File: rtl/video_pkg.sv
// Shared definitions for the framebuffer video path: pixel width, default line
// length and the handshake/strobe semantics shared with vga_timing.
package video_pkg;

    localparam int PIX_DW           = 16;
    localparam int LINE_PIX_DEFAULT = 640;

    // A pixel moves on an edge where the source is valid and the sink is
    // ready, unless the one-cycle sync strobe is claiming that edge.
    function automatic logic xfer(input logic valid, input logic ready, input logic sync);
        return valid && ready && !sync;
    endfunction

endpackage

// File: rtl/line_ram.sv
// Simple dual-port line store: one write port, one read port with a
// registered read (one cycle from address to data).
module line_ram
    import video_pkg::*;
#(
    parameter int DW    = PIX_DW,
    parameter int DEPTH = 2 * LINE_PIX_DEFAULT,
    parameter int ADW   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           we,
    input  logic [ADW-1:0] waddr,
    input  logic [DW-1:0]  wdata,
    input  logic [ADW-1:0] raddr,
    output logic [DW-1:0]  rdata
);

    logic [DW-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it can map onto block RAM; stale contents
    // are never observed because every bank is rewritten before it is replayed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/line_doubler.sv
// Vertical scan-doubler: fills one bank of a ping-pong line store while the
// other bank is replayed twice through a 2-entry output FIFO.
module line_doubler
    import video_pkg::*;
#(
    parameter int DW       = PIX_DW,
    parameter int LINE_PIX = LINE_PIX_DEFAULT,
    parameter int AW       = $clog2(LINE_PIX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sync,
    input  logic          din_valid,
    output logic          din_ready,
    input  logic [DW-1:0] din,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [DW-1:0] dout
);

    localparam int            AW1      = AW + 1;
    localparam logic [AW-1:0] LAST     = AW'(LINE_PIX - 1);
    localparam logic [AW:0]   BANK_OFS = AW1'(LINE_PIX);

    logic          wbank, wfull;
    logic [AW-1:0] wptr;
    logic          rbusy, pass, rd_pending;
    logic [AW-1:0] rptr;
    logic [AW:0]   waddr, raddr;
    logic [DW-1:0] rdata;

    logic [DW-1:0] fifo_q [2];
    logic          fifo_rd, fifo_wr;
    logic [1:0]    fifo_cnt;

    logic accept, pop, push, swap, fetch;

    assign din_ready  = !wfull && !rst;
    assign accept     = xfer(din_valid, din_ready, sync);
    assign dout_valid = (fifo_cnt != 2'd0);
    assign dout       = fifo_q[fifo_rd];
    assign pop        = xfer(dout_valid, dout_ready, sync);
    assign push       = rd_pending && !sync;
    assign swap       = wfull && !rbusy && !sync;

    // Room is judged after this cycle's pop, which sustains 1 pixel/cycle
    // while never letting occupancy plus the in-flight read exceed two.
    assign fetch = rbusy && !sync &&
                   ((3'(fifo_cnt) + 3'(rd_pending) - 3'(pop)) < 3'd2);

    // Bank 1 starts at LINE_PIX so the store is exactly two lines deep.
    assign waddr = (wbank  ? BANK_OFS : '0) + {1'b0, wptr};
    assign raddr = (!wbank ? BANK_OFS : '0) + {1'b0, rptr};

    line_ram #(
        .DW    (DW),
        .DEPTH (2 * LINE_PIX),
        .ADW   (AW1)
    ) u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr (waddr),
        .wdata (din),
        .raddr (raddr),
        .rdata (rdata)
    );

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || sync) begin
            wbank      <= 1'b0;
            wfull      <= 1'b0;
            wptr       <= '0;
            rbusy      <= 1'b0;
            pass       <= 1'b0;
            rptr       <= '0;
            rd_pending <= 1'b0;
            fifo_rd    <= 1'b0;
            fifo_wr    <= 1'b0;
            fifo_cnt   <= 2'd0;
        end else begin
            if (accept) begin
                if (wptr == LAST) begin
                    wptr  <= '0;
                    wfull <= 1'b1;
                end else begin
                    wptr <= wptr + AW'(1);
                end
            end

            if (swap) begin
                wbank <= !wbank;
                wfull <= 1'b0;
                rbusy <= 1'b1;
                rptr  <= '0;
                pass  <= 1'b0;
            end

            rd_pending <= fetch;
            if (fetch) begin
                if (rptr == LAST) begin
                    rptr <= '0;
                    if (!pass) begin
                        pass <= 1'b1;
                    end else begin
                        rbusy <= 1'b0;
                        pass  <= 1'b0;
                    end
                end else begin
                    rptr <= rptr + AW'(1);
                end
            end

            if (push) fifo_wr <= !fifo_wr;
            if (pop)  fifo_rd <= !fifo_rd;
            fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
        end
    end

    // The FIFO payload is reset only by rst so dout reads zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_q <= '{default: '0};
        end else if (push) begin
            fifo_q[fifo_wr] <= rdata;
        end
    end

endmodule

// File: tb/tb_line_doubler.sv
// Scoreboard bench for line_doubler: every completed input line is expected
// twice on the output, in order; sync/rst drop everything not yet emitted.
module tb_line_doubler;

    localparam int DW = 16;
    localparam int LP = 4;

    logic          clk = 1'b0;
    logic          rst, sync, din_valid, din_ready, dout_valid, dout_ready;
    logic [DW-1:0] din, dout;

    always #5 clk = ~clk;

    line_doubler #(.DW(DW), .LINE_PIX(LP)) dut (
        .clk        (clk),
        .rst        (rst),
        .sync       (sync),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din        (din),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout       (dout)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ready_mode = 0;   // 0: ready high, 1: ready low, 2: random 50%
    int accepted = 0;
    int out_cnt = 0;
    int last_acc_edge = 0;
    int last_xfer_edge = 0;
    int last_gap = 0;

    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] part_q [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        dout_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       dout_ready = 1'b1;
                1:       dout_ready = 1'b0;
                default: dout_ready = 1'($urandom_range(1, 0));
            endcase
        end
    end

    // Monitor/model: samples at negedge what the next rising edge will do.
    initial begin
        logic          prev_stall;
        logic [DW-1:0] prev_dout;
        prev_stall = 1'b0;
        prev_dout  = '0;
        forever begin
            @(negedge clk);
            if (rst || sync) begin
                exp_q.delete();
                part_q.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", dout_valid, 1'b1);
                    check("stall_data", dout, prev_dout);
                end
                if (dout_valid && dout_ready) begin
                    if (exp_q.size() == 0) fail_now($sformatf("unexpected_out got=%0h want=none", dout));
                    else check("dout", dout, exp_q.pop_front());
                    out_cnt++;
                    last_gap       = (cyc + 1) - last_xfer_edge - 1;
                    last_xfer_edge = cyc + 1;
                end
                if (din_valid && din_ready) begin
                    accepted++;
                    last_acc_edge = cyc + 1;
                    part_q.push_back(din);
                    if (part_q.size() == LP) begin
                        repeat (2) foreach (part_q[i]) exp_q.push_back(part_q[i]);
                        part_q.delete();
                    end
                end
                prev_stall = dout_valid && !dout_ready;
                prev_dout  = dout;
            end
        end
    end

    // Offer one pixel (optionally after random idle cycles) until accepted.
    task automatic send(input logic [DW-1:0] v, input bit gaps);
        int n;
        n = 0;
        if (gaps) begin
            while ($urandom_range(1, 0) == 1) begin
                @(posedge clk);
                #1;
            end
        end
        din       = v;
        din_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (din_ready && !sync) break;
            n++;
            if (n > 300) begin
                fail_now($sformatf("send_timeout pixel=%0h", v));
                break;
            end
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic send_line(input logic [DW-1:0] base, input bit gaps);
        for (int i = 0; i < LP; i++) send(base + DW'(i), gaps);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 1000) fail_now($sformatf("drain_timeout left=%0d", exp_q.size()));
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("idle_after_drain", dout_valid, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a, rise, base, n;
        rst = 1'b1; sync = 1'b0; din_valid = 1'b1; din = 16'hdead;

        // Reset held with din_valid high.
        repeat (3) begin
            @(negedge clk);
            check("rst_din_ready", din_ready, 1'b0);
            check("rst_dout_valid", dout_valid, 1'b0);
            check("rst_dout", dout, '0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        check("post_rst_din_ready", din_ready, 1'b1);
        @(posedge clk);
        #1;

        // Basic doubling and first-pixel latency.
        ready_mode = 0;
        for (int i = 1; i <= 4; i++) send(DW'(i), 1'b0);
        a = last_acc_edge;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dout_valid && n < 20);
        rise = cyc;
        check("first_latency", rise - a, 3);
        for (int i = 1; i < 2 * LP; i++) begin
            @(negedge clk);
            check("consecutive_valid", dout_valid, 1'b1);
        end
        @(posedge clk);
        #1;
        drain();

        // Backpressure: A and B fit, C waits until A's replay finishes.
        ready_mode = 1;
        base = accepted;
        fork
            begin
                send_line(16'd10, 1'b0);
                send_line(16'd20, 1'b0);
                send_line(16'd30, 1'b0);
            end
            begin
                repeat (30) @(posedge clk);
                @(negedge clk);
                check("bp_accepted", accepted - base, 2 * LP);
                check("bp_din_ready", din_ready, 1'b0);
                check("bp_head", dout, 16'd10);
                @(posedge clk);
                #1;
                ready_mode = 0;
            end
        join
        drain();

        // Random stalls on both sides over 8 lines.
        ready_mode = 2;
        for (int l = 0; l < 8; l++) begin
            for (int i = 0; i < LP; i++) send(DW'($urandom()), 1'b1);
        end
        drain();
        ready_mode = 0;
        drain();

        // Coincident line completion and final fetch of the previous pass.
        base = out_cnt;
        send_line(16'h100, 1'b0);
        a = last_acc_edge;
        while (cyc < a + 5) begin
            @(posedge clk);
            #1;
        end
        send_line(16'h200, 1'b0);
        check("coinc_accept_edge", last_acc_edge, a + 9);
        n = 0;
        while (out_cnt < base + 2 * LP + 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("coinc_bubble", last_gap, 1);
        @(posedge clk);
        #1;
        drain();

        // Sync mid-line with replay data queued; a pixel offered during sync is dropped.
        ready_mode = 1;
        send_line(16'd60, 1'b0);
        send(16'd50, 1'b0);
        send(16'd51, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        sync = 1'b1;
        din = 16'h77;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        sync = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        check("sync_dout_valid", dout_valid, 1'b0);
        check("sync_din_ready", din_ready, 1'b1);
        @(posedge clk);
        #1;
        ready_mode = 0;
        base = out_cnt;
        send_line(16'd40, 1'b0);
        drain();
        check("sync_out_count", out_cnt - base, 2 * LP);

        check("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

endmodule
